inst_stream_loader: RTL
=======================

Name: inst_stream_loader

Overview:
- Producer side of the instruction-load handshake that the control FSM consumes (FSM inputs inst_available/start, FSM output inst_mem_en).
- Accepts program bytes from a host byte stream (valid/ready) and buffers them in a small FIFO.
- Presents buffered bytes to instruction memory at sequential addresses while the FSM grants writes.
- After the last byte is written, pulses start so the FSM leaves its instruction-wait state and begins execution.

Parameters:
- ADDR_W, 8, instruction memory address width.
- MEM_DEPTH, 256, number of writable instruction bytes; must be <= 2^ADDR_W.
- FIFO_DEPTH, 4, staging FIFO entries; power of two, >= 2.

Ports:
- clka  in  1  single system clock; all logic on rising edge.
- restart  in  1  synchronous, active-high reset.
- host_valid  in  1  host byte valid.
- host_data  in  8  host program byte.
- host_last  in  1  qualifies host_data as the final program byte; ignored when host_valid=0.
- host_ready  out  1  loader can accept a byte this cycle.
- inst_mem_en  in  1  write grant from control FSM.
- inst_available  out  1  FIFO holds at least one byte to be written.
- inst_we  out  1  instruction memory write strobe.
- inst_addr  out  ADDR_W  instruction memory write address.
- inst_data  out  8  instruction memory write data (FIFO head).
- start  out  1  one-cycle pulse: program fully loaded.
- overflow  out  1  sticky: program exceeded MEM_DEPTH.
- load_count  out  ADDR_W+1  bytes written to memory so far.

Behaviour:
- Reset: synchronous, active-high on restart, highest priority, valid in any state. Effects: state=LOAD; FIFO empty; addr=0; load_count=0; start=0; overflow=0.
- After restart, in LOAD, the outputs are: host_ready=1, inst_available=0, inst_we=0.
- Push: a byte is accepted when host_valid && host_ready.
- host_ready = (state==LOAD) && (count<FIFO_DEPTH). It is combinational from registered state.
- inst_available = (count!=0) && (state==LOAD || state==FLUSH). It is derived from registers only.
- Pop/write condition: inst_mem_en && count!=0 && state in {LOAD, FLUSH}.
  - The FIFO pops on that cycle.
  - inst_we = pop && !overflow && addr<MEM_DEPTH.
  - inst_data = FIFO head; inst_addr = addr (combinational outputs).
- On a write: addr and load_count increment by 1.
- If a pop occurs while addr==MEM_DEPTH: overflow is set, the byte is discarded, and addr holds.
- Simultaneous push and pop: count unchanged; FIFO order preserved. A push into a full FIFO cannot occur because host_ready=0.
- Write latency: a byte accepted at cycle N is writable no earlier than N+1. With inst_mem_en held high and the FIFO empty, each byte is written exactly 1 cycle after acceptance.
- FSM states:
  - LOAD: accepting bytes. A push with host_last=1 -> FLUSH.
  - FLUSH: host_ready=0; drain continues. Transitions:
    - count reaches 0 with overflow=0 -> START.
    - count reaches 0 with overflow=1 -> ERR.
  - START: start=1 for exactly one cycle -> DONE.
  - DONE: host_ready=0, inst_available=0, inst_we=0; all inputs ignored until restart.
  - ERR: same as DONE, with overflow=1 and no start pulse ever.
- The last byte and a pop may coincide. The FLUSH->START decision uses the post-update count, so start fires the cycle after the final write.
- When inst_mem_en=0, bytes accumulate; when the FIFO is full, the host is back-pressured. No byte is ever lost or duplicated.
- Restart mid-operation (any state, including FLUSH with data buffered): buffered bytes are dropped and the next load begins at addr 0.
- load_count saturates at MEM_DEPTH.

Test Plan:
- Program A9,05,00 (last on 00), inst_mem_en=1 throughout -> inst_we at addr 0,1,2 with data A9,05,00 on consecutive cycles. start=1 one cycle after the addr-2 write. load_count=3; state DONE; host_ready=0.
- inst_mem_en=0, host offers 5 bytes 10..14 -> 10..13 accepted, host_ready=0 with count=4, inst_available=1. Raise inst_mem_en -> addr 0..3 written with 10..13, then 14 accepted and written at addr 4; no byte lost.
- Continuous host_valid with inst_mem_en=1 for 20 bytes -> count never exceeds 1. Addresses 0..19 are contiguous with matching data; start pulses once.
- MEM_DEPTH=8, send 9 bytes (last on 9th) -> 8 writes at addr 0..7. 9th byte popped with inst_we=0; overflow=1; state ERR; start never asserted.
- Restart asserted in FLUSH with 2 bytes buffered -> next cycle: FIFO empty, addr=0, overflow=0, start=0, host_ready=1. Reload of 1 byte writes addr 0.
- inst_mem_en toggling 1/0 each cycle during a 6-byte load -> writes only on enabled cycles; order and addresses intact; a single start pulse after the final write.

Source files
------------

// File: rtl/inst_stream_loader_if.sv
// Host byte stream and instruction-memory write port of the program loader.
// The master modport is the loader side; the slave modport is its environment.
interface inst_stream_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              host_valid;
    logic [7:0]        host_data;
    logic              host_last;
    logic              host_ready;
    logic              inst_mem_en;
    logic              inst_available;
    logic              inst_we;
    logic [ADDR_W-1:0] inst_addr;
    logic [7:0]        inst_data;
    logic              start;
    logic              overflow;
    logic [ADDR_W:0]   load_count;

    modport master (
        input  host_valid, host_data, host_last, inst_mem_en,
        output host_ready, inst_available, inst_we, inst_addr, inst_data,
        output start, overflow, load_count
    );

    modport slave (
        output host_valid, host_data, host_last, inst_mem_en,
        input  host_ready, inst_available, inst_we, inst_addr, inst_data,
        input  start, overflow, load_count
    );
endinterface

// File: rtl/inst_stream_loader.sv
// Stages host program bytes in a small FIFO and writes them to instruction memory
// at sequential addresses while the control FSM grants; pulses start once loaded.
module inst_stream_loader #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clka,
    input  logic                 restart,
    inst_stream_loader_if.master bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W + 1)'(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_LOAD,
        S_FLUSH,
        S_START,
        S_DONE,
        S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ADDR_W:0]  addr_q, addr_d;
    logic             overflow_q, overflow_d;

    logic accepting_c;
    logic draining_c;
    logic ready_c;
    logic push_c;
    logic pop_c;
    logic at_limit_c;
    logic we_c;

    // Handshake qualifiers, all derived from registered state plus live inputs.
    always_comb begin
        accepting_c = (state_q == S_LOAD);
        draining_c  = (state_q == S_LOAD) || (state_q == S_FLUSH);
        ready_c     = accepting_c && (count_q < FIFO_FULL);
        push_c      = bus.host_valid && ready_c;
        pop_c       = bus.inst_mem_en && (count_q != '0) && draining_c;
        at_limit_c  = (addr_q == MEM_LIMIT);
        we_c        = pop_c && !overflow_q && !at_limit_c;
    end

    // Next-state and datapath update; the FLUSH exit looks at post-update count/overflow.
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_c);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_c);
        count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        addr_d     = we_c ? addr_q + (ADDR_W + 1)'(1) : addr_q;
        overflow_d = overflow_q || (pop_c && at_limit_c);

        case (state_q)
            S_LOAD: begin
                if (push_c && bus.host_last) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (count_d == '0) begin
                    state_d = overflow_d ? S_ERR : S_START;
                end
            end
            S_START: state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            state_q    <= S_LOAD;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been pushed.
    always_ff @(posedge clka) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= bus.host_data;
        end
    end

    // addr never passes MEM_DEPTH, so it doubles as the saturating byte count.
    assign bus.host_ready     = ready_c;
    assign bus.inst_available = (count_q != '0) && draining_c;
    assign bus.inst_we        = we_c;
    assign bus.inst_addr      = addr_q[ADDR_W-1:0];
    assign bus.inst_data      = fifo_q[rd_ptr_q];
    assign bus.start          = (state_q == S_START);
    assign bus.overflow       = overflow_q;
    assign bus.load_count     = addr_q;
endmodule
